sevenseg_digit_counter: RTL and testbench

- Upstream digit source for the static active-low seven-segment driver.
- Produces a registered BCD digit (0-9) plus a change strobe. The downstream decoder converts the digit into segment levels a..g.
- The digit advances in one of two ways:
  - Auto mode: a prescaled timebase.
  - Manual mode: a synchronised, debounced push-button.
- Direction is up/down, with decimal wrap and a carry/borrow pulse for chaining further digits.

---
 rtl/sevenseg_digit_counter_if.sv | 25 ++
 rtl/sevenseg_digit_counter.sv | 123 ++++++++++++
 tb/tb_sevenseg_digit_counter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/sevenseg_digit_counter_if.sv
// Control inputs and digit outputs of the single-digit counter.
// Latency: pure wiring, no state.
// Backpressure: none; the digit and strobes are fire-and-forget.
interface sevenseg_digit_counter_if;
  logic       en;
  logic       auto_mode;
  logic       up;
  logic       step_btn;
  logic       clr;
  logic [3:0] digit;
  logic       digit_stb;
  logic       carry;

  // Drives the controls and observes the digit (e.g. a testbench or parent).
  modport master (
    output en, auto_mode, up, step_btn, clr,
    input  digit, digit_stb, carry
  );

  // The counter itself.
  modport slave (
    input  en, auto_mode, up, step_btn, clr,
    output digit, digit_stb, carry
  );
endinterface

// File: rtl/sevenseg_digit_counter.sv
// BCD digit counter (0-9, up/down) advanced by a prescaled tick or a debounced button.
// Latency: digit/stb/carry registered; button press reaches the digit at edge 3+DB_CYCLES.
// Backpressure: none; advances not taken (en=0, wrong mode) are dropped, never queued.
module sevenseg_digit_counter #(
  parameter int unsigned TICK_DIV  = 12000000,
  parameter int unsigned DB_CYCLES = 120000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  sevenseg_digit_counter_if.slave      bus
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = $clog2(DB_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] DB_LAST    = CW'(DB_CYCLES - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          deb_q, deb_d;
  logic          deb_prev_q, deb_prev_d;
  logic [CW-1:0] db_cnt_q, db_cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    digit_q, digit_d;
  logic          stb_q, stb_d;
  logic          carry_q, carry_d;

  logic          run;
  logic          tick;
  logic          step_evt;
  logic          advance;

  // Two-flop synchroniser; nothing looks at step_btn before s2.
  always_comb begin
    s1_d = bus.step_btn;
    s2_d = s1_q;
  end

  // Debounce: accept s2 only after DB_CYCLES consecutive cycles differing from the held level.
  always_comb begin
    deb_d      = deb_q;
    db_cnt_d   = '0;
    deb_prev_d = deb_q;
    if (s2_q != deb_q) begin
      if (db_cnt_q == DB_LAST) begin
        deb_d    = s2_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Prescaler runs only in enabled auto mode and restarts from zero on clear or mode exit.
  always_comb begin
    run      = bus.en & bus.auto_mode;
    tick     = run & (presc_q == PRESC_LAST);
    step_evt = deb_q & ~deb_prev_q;
    advance  = bus.en & (bus.auto_mode ? tick : step_evt);
    presc_d  = '0;
    if (run && !bus.clr && !tick) begin
      presc_d = presc_q + 1'b1;
    end
  end

  // Digit update: clear wins over advance; wraps are explicit compares, carry marks them.
  always_comb begin
    digit_d = digit_q;
    stb_d   = 1'b0;
    carry_d = 1'b0;
    if (bus.clr) begin
      digit_d = 4'd0;
      stb_d   = 1'b1;
    end else if (advance) begin
      stb_d = 1'b1;
      if (bus.up) begin
        if (digit_q == 4'd9) begin
          digit_d = 4'd0;
          carry_d = 1'b1;
        end else begin
          digit_d = digit_q + 4'd1;
        end
      end else begin
        if (digit_q == 4'd0) begin
          digit_d = 4'd9;
          carry_d = 1'b1;
        end else begin
          digit_d = digit_q - 4'd1;
        end
      end
    end
  end

  // State register; reset discards all counting and debounce progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      db_cnt_q   <= '0;
      presc_q    <= '0;
      digit_q    <= 4'd0;
      stb_q      <= 1'b0;
      carry_q    <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      db_cnt_q   <= db_cnt_d;
      presc_q    <= presc_d;
      digit_q    <= digit_d;
      stb_q      <= stb_d;
      carry_q    <= carry_d;
    end
  end

  assign bus.digit     = digit_q;
  assign bus.digit_stb = stb_q;
  assign bus.carry     = carry_q;

endmodule

// File: tb/tb_sevenseg_digit_counter.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
// Latency: model and DUT are compared every falling edge.
// Backpressure: not applicable.
module tb_sevenseg_digit_counter;
  localparam int TICK_DIV  = 4;
  localparam int DB_CYCLES = 3;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  sevenseg_digit_counter_if bus ();

  sevenseg_digit_counter #(.TICK_DIV(TICK_DIV), .DB_CYCLES(DB_CYCLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural reference: button history queue, run-length debounce, enabled-edge phase,
  // and modulo-10 digit arithmetic.
  int btn_hist[$];
  int m_level;
  int m_diff_run;
  int m_rise_pending;
  int m_phase;
  int m_digit;
  int m_stb;
  int m_carry;

  always @(posedge clk or negedge rst_n) begin : model
    int s2_view;
    int tick;
    int adv;
    if (!rst_n) begin
      btn_hist.delete();
      m_level = 0; m_diff_run = 0; m_rise_pending = 0;
      m_phase = 0; m_digit = 0; m_stb = 0; m_carry = 0;
    end else begin
      s2_view = (btn_hist.size() >= 2) ? btn_hist[btn_hist.size()-2] : 0;
      tick = (bus.en && bus.auto_mode && m_phase == TICK_DIV - 1) ? 1 : 0;
      adv  = bus.en ? (bus.auto_mode ? tick : m_rise_pending) : 0;
      m_stb = 0; m_carry = 0;
      if (bus.clr) begin
        m_digit = 0; m_stb = 1;
      end else if (adv != 0) begin
        m_stb = 1;
        if (bus.up) begin
          m_carry = (m_digit == 9) ? 1 : 0;
          m_digit = (m_digit + 1) % 10;
        end else begin
          m_carry = (m_digit == 0) ? 1 : 0;
          m_digit = (m_digit + 9) % 10;
        end
      end
      if (bus.clr || !(bus.en && bus.auto_mode)) m_phase = 0;
      else m_phase = (m_phase + 1) % TICK_DIV;
      m_rise_pending = 0;
      if (s2_view != m_level) begin
        m_diff_run++;
        if (m_diff_run == DB_CYCLES) begin
          m_level = s2_view;
          m_diff_run = 0;
          m_rise_pending = m_level;
        end
      end else begin
        m_diff_run = 0;
      end
      btn_hist.push_back(int'(bus.step_btn));
      if (btn_hist.size() > 2) void'(btn_hist.pop_front());
    end
  end

  // Continuous comparison of the DUT against the model.
  always @(negedge clk) begin
    check("digit_vs_model", int'(bus.digit), m_digit);
    check("stb_vs_model",   int'(bus.digit_stb), m_stb);
    check("carry_vs_model", int'(bus.carry), m_carry);
  end

  initial begin
    int stb_cnt;
    int carry_cnt;
    int hold;
    tests_run = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    bus.en = 1'b0; bus.auto_mode = 1'b0; bus.up = 1'b0;
    bus.step_btn = 1'b0; bus.clr = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_digit", int'(bus.digit), 0);
    check("reset_stb", int'(bus.digit_stb), 0);
    check("reset_carry", int'(bus.carry), 0);
    rst_n = 1'b1;

    // Auto up-count for 44 edges: 11 advances, one wrap.
    bus.en = 1'b1; bus.auto_mode = 1'b1; bus.up = 1'b1;
    stb_cnt = 0; carry_cnt = 0;
    for (int i = 1; i <= 44; i++) begin
      @(negedge clk);
      stb_cnt += int'(bus.digit_stb);
      carry_cnt += int'(bus.carry);
      if (i == 40) check("wrap_carry", int'(bus.carry), 1);
    end
    check("auto_stb_count", stb_cnt, 11);
    check("auto_carry_count", carry_cnt, 1);
    check("auto_final_digit", int'(bus.digit), 1);

    // Down count from zero: borrow on 0->9.
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0; bus.up = 1'b0;
    repeat (3) @(negedge clk);
    check("down_before_tick", int'(bus.digit), 0);
    @(negedge clk);
    check("down_first", int'(bus.digit), 9);
    check("down_borrow", int'(bus.carry), 1);
    repeat (4) @(negedge clk);
    check("down_8", int'(bus.digit), 8);
    check("down_8_carry", int'(bus.carry), 0);
    repeat (4) @(negedge clk);
    check("down_7", int'(bus.digit), 7);

    // Manual clean press: digit changes exactly at edge 6.
    bus.auto_mode = 1'b0; bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0; bus.up = 1'b1; bus.step_btn = 1'b1;
    repeat (5) @(negedge clk);
    check("press_edge5", int'(bus.digit), 0);
    @(negedge clk);
    check("press_edge6", int'(bus.digit), 1);
    check("press_stb", int'(bus.digit_stb), 1);
    repeat (4) @(negedge clk);
    bus.step_btn = 1'b0;
    repeat (10) @(negedge clk);
    check("release_no_change", int'(bus.digit), 1);

    // Bouncy press: one advance, 6 edges after the final rise.
    bus.step_btn = 1'b1; @(negedge clk);
    bus.step_btn = 1'b0; @(negedge clk);
    bus.step_btn = 1'b1; @(negedge clk);
    bus.step_btn = 1'b0; @(negedge clk);
    bus.step_btn = 1'b1;
    repeat (5) @(negedge clk);
    check("bounce_edge5", int'(bus.digit), 1);
    @(negedge clk);
    check("bounce_edge6", int'(bus.digit), 2);
    repeat (6) @(negedge clk);
    check("bounce_single", int'(bus.digit), 2);
    bus.step_btn = 1'b0;
    repeat (10) @(negedge clk);

    // Clear beats a simultaneous tick.
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0; bus.auto_mode = 1'b1;
    repeat (28) @(negedge clk);
    check("prio_setup", int'(bus.digit), 7);
    repeat (3) @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    check("prio_digit", int'(bus.digit), 0);
    check("prio_stb", int'(bus.digit_stb), 1);
    check("prio_carry", int'(bus.carry), 0);
    repeat (3) @(negedge clk);
    check("prio_wait", int'(bus.digit), 0);
    @(negedge clk);
    check("prio_next", int'(bus.digit), 1);

    // Asynchronous reset with prescaler=2, digit=5.
    repeat (18) @(negedge clk);
    check("rst_setup", int'(bus.digit), 5);
    #2 rst_n = 1'b0;
    #1 check("async_rst_digit", int'(bus.digit), 0);
    check("async_rst_stb", int'(bus.digit_stb), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_wait", int'(bus.digit), 0);
    @(negedge clk);
    check("post_rst_first", int'(bus.digit), 1);

    // Press with en=0 is dropped and not replayed when en returns.
    bus.en = 1'b0; bus.auto_mode = 1'b0; bus.step_btn = 1'b1;
    repeat (10) @(negedge clk);
    bus.step_btn = 1'b0;
    repeat (10) @(negedge clk);
    check("en0_press", int'(bus.digit), 1);
    bus.en = 1'b1;
    repeat (10) @(negedge clk);
    check("en0_not_queued", int'(bus.digit), 1);

    // Random traffic against the model.
    hold = 0;
    for (int i = 0; i < 800; i++) begin
      if (i % 40 == 0) bus.auto_mode = ($urandom_range(0, 2) == 0);
      bus.en  = ($urandom_range(0, 7) != 0);
      bus.up  = ($urandom_range(0, 9) < 6);
      bus.clr = ($urandom_range(0, 31) == 0);
      if (hold == 0) begin
        bus.step_btn = $urandom_range(0, 1);
        hold = $urandom_range(1, 8);
      end
      hold--;
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
